// File: rtl/kyber_pkg.sv
// kyber_pkg: constants and FSM encoding shared by the Kyber datapath blocks
// (poly_addsub_engine, mini_fsm, NTT stages).
//   Q    - Kyber modulus
//   N    - coefficients per polynomial
//   CW   - coefficient width in bits
//   AW   - coefficient address width, log2(N)
//   ST_* - engine FSM state encoding, exposed on the debug state output
package kyber_pkg;

    localparam int unsigned Q  = 3329;
    localparam int unsigned N  = 256;
    localparam int unsigned CW = 12;
    localparam int unsigned AW = 8;

    // Modulus at CW+1 bits, the width used for the pre-correction sum/difference.
    localparam logic [CW:0] Q_W = (CW+1)'(Q);

    typedef logic [CW-1:0] coeff_t;
    typedef logic [AW-1:0] addr_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/poly_addsub_engine_if.sv
// poly_addsub_engine_if: control and RAM-side signals of the add/sub engine.
//   start_pulse, op_sub : one-cycle start request and operation select
//   busy, done          : run status and one-cycle completion pulse
//   rd_en, rd_addr      : shared synchronous read port of RAMs A and B
//   a_data, b_data      : read data, valid one cycle after rd_en
//   wr_en, wr_addr,
//   wr_data             : write port of RAM C
//   state               : debug view of the engine FSM
// Handshake: there is no backpressure. start_pulse is honoured only when the
// engine is idle (busy=0, done=0); reads issue every cycle of a run and read
// data is consumed exactly one cycle after its rd_en, so the RAMs must have a
// fixed one-cycle read latency.
// master = engine side, slave = control bank / RAM side.
interface poly_addsub_engine_if;
    import kyber_pkg::*;

    logic       start_pulse;
    logic       op_sub;
    logic       busy;
    logic       done;
    logic       rd_en;
    addr_t      rd_addr;
    coeff_t     a_data;
    coeff_t     b_data;
    logic       wr_en;
    addr_t      wr_addr;
    coeff_t     wr_data;
    logic [1:0] state;

    modport master (
        input  start_pulse, op_sub, a_data, b_data,
        output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, state
    );

    modport slave (
        output start_pulse, op_sub, a_data, b_data,
        input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, state
    );

endinterface

// File: rtl/mod_addsub.sv
// mod_addsub: combinational modular add/subtract modulo Q.
//   a, b   : operands, expected in [0, Q-1]
//   sub    : 0 -> a+b mod Q, 1 -> a-b mod Q
//   result : in [0, Q-1] for in-range operands
// Only a single conditional correction is applied; out-of-range operands
// give an unspecified (but deterministic) result.
module mod_addsub
    import kyber_pkg::*;
(
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          sub,
    output logic [CW-1:0] result
);

    logic [CW:0] sum;
    logic [CW:0] diff;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        result = '0;
        if (sub) begin
            // diff[CW] is the sign of a-b; adding Q modulo 2^(CW+1) lands in range.
            result = diff[CW] ? CW'(diff + Q_W) : diff[CW-1:0];
        end else begin
            result = (sum >= Q_W) ? CW'(sum - Q_W) : sum[CW-1:0];
        end
    end

endmodule

// File: rtl/poly_addsub_engine.sv
// poly_addsub_engine: coefficient-wise C = A +/- B mod Q over N coefficients.
//   clk, rst : clock, synchronous active-high reset
//   bus      : poly_addsub_engine_if.master (start/op, status, RAM ports, debug state)
// Pipeline: read issued after E(k), RAM data valid after E(k+1), registered
// result written after E(k+2). done follows the last write by one cycle,
// giving a start-to-done latency of N+2 cycles.
module poly_addsub_engine
    import kyber_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    poly_addsub_engine_if.master   bus
);

    logic [1:0] state;
    logic       op_q;
    logic       rd_en_d1;
    addr_t      rd_addr_d1;
    coeff_t     result;

    mod_addsub u_mod_addsub (
        .a      (bus.a_data),
        .b      (bus.b_data),
        .sub    (op_q),
        .result (result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_q        <= 1'b0;
            bus.rd_en   <= 1'b0;
            bus.rd_addr <= '0;
            rd_en_d1    <= 1'b0;
            rd_addr_d1  <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            // Stage 1: track which address the RAM data belongs to.
            rd_en_d1   <= bus.rd_en;
            rd_addr_d1 <= bus.rd_addr;

            // Stage 2: register the corrected result for RAM C.
            bus.wr_en <= rd_en_d1;
            if (rd_en_d1) begin
                bus.wr_addr <= rd_addr_d1;
                bus.wr_data <= result;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.start_pulse) begin
                        state       <= ST_RUN;
                        op_q        <= bus.op_sub;
                        bus.rd_en   <= 1'b1;
                        bus.rd_addr <= '0;
                    end
                end
                ST_RUN: begin
                    // Address wraps to 0 after N-1; terminal count is the compare.
                    bus.rd_addr <= bus.rd_addr + AW'(1);
                    if (bus.rd_addr == AW'(N - 1)) begin
                        bus.rd_en <= 1'b0;
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Once stage 1 is empty, the last write is being issued now.
                    if (!rd_en_d1) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = (state == ST_RUN) || (state == ST_DRAIN);
    assign bus.done  = (state == ST_DONE);
    assign bus.state = state;

endmodule
